// File: rtl/ysyx_24100005_ifu_if.sv
// Signal bundle between the fetch unit, instruction memory and the decode stage.
// master = fetch unit side, slave = memory/consumer side.
interface ysyx_24100005_ifu_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc,
        output perf_fetch_cnt,
        output perf_stall_cnt
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready,
        output redirect_valid,
        output redirect_pc,
        input  perf_fetch_cnt,
        input  perf_stall_cnt
    );
endinterface

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: single-outstanding word fetch into a small {pc, inst} FIFO.
// Optional perf counters are built when YSYX_24100005_IFU_PERF_EN is defined.
module ysyx_24100005_ifu #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_24100005_ifu_if.master bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetchPc;
    logic [31:0]   r_pendPc;
    logic [31:0]   r_instMem [DEPTH];
    logic [31:0]   r_pcMem   [DEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;
    logic          r_instValid;

    logic          w_reqValid;
    logic          w_reqFire;
    logic          w_push;
    logic          w_pop;
    logic          w_redirect;
    logic [CW-1:0] w_countNext;

    // A request only goes out when a FIFO slot is guaranteed for its response.
    assign w_redirect = bus.redirect_valid;
    assign w_reqValid = (r_state == IDLE) && (r_count < CW'(DEPTH)) && !w_redirect;
    assign w_reqFire  = w_reqValid && bus.req_ready;
    assign w_push     = (r_state == WAIT) && bus.rsp_valid && !w_redirect;
    assign w_pop      = r_instValid && bus.inst_ready && !w_redirect;

    always_comb begin
        w_countNext = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_fetchPc <= RESET_PC;
            r_pendPc  <= 32'h0;
        end else if (w_redirect) begin
            r_fetchPc <= bus.redirect_pc & 32'hFFFF_FFFC;
            case (r_state)
                WAIT:    r_state <= bus.rsp_valid ? IDLE : KILL;
                KILL:    r_state <= bus.rsp_valid ? IDLE : KILL;
                default: r_state <= IDLE;
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_reqFire) begin
                        r_state   <= WAIT;
                        r_pendPc  <= r_fetchPc;
                        r_fetchPc <= r_fetchPc + 32'd4;
                    end
                end
                WAIT: begin
                    if (bus.rsp_valid) begin
                        r_state <= IDLE;
                    end
                end
                KILL: begin
                    if (bus.rsp_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_instValid <= 1'b0;
        end else if (w_redirect) begin
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_instValid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_count     <= w_countNext;
            r_instValid <= (w_countNext != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instMem[i] <= 32'h0;
                r_pcMem[i]   <= 32'h0;
            end
        end else if (w_push) begin
            r_instMem[r_wrPtr] <= bus.rsp_data;
            r_pcMem[r_wrPtr]   <= r_pendPc;
        end
    end

    // Head outputs read zero while the FIFO is empty so stale entries never leak.
    assign bus.req_valid  = w_reqValid;
    assign bus.req_addr   = r_fetchPc;
    assign bus.inst_valid = r_instValid;
    assign bus.inst       = r_instValid ? r_instMem[r_rdPtr] : 32'h0;
    assign bus.inst_pc    = r_instValid ? r_pcMem[r_rdPtr]   : 32'h0;

`ifdef YSYX_24100005_IFU_PERF_EN
    logic [31:0] r_perfFetch;
    logic [31:0] r_perfStall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perfFetch <= 32'h0;
            r_perfStall <= 32'h0;
        end else begin
            if (w_push) begin
                r_perfFetch <= r_perfFetch + 32'd1;
            end
            if (bus.inst_ready && !r_instValid) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt = r_perfFetch;
    assign bus.perf_stall_cnt = r_perfStall;
`else
    assign bus.perf_fetch_cnt = 32'h0;
    assign bus.perf_stall_cnt = 32'h0;
`endif

endmodule
